// File: rtl/reg_dump_uart.sv
// Register-file dump engine: stalls the core, walks debug_reg_addr over every register
// and streams a sync header plus each 64-bit value (MSB byte first) out as 8N1 UART frames.
module reg_dump_uart #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          NUM_REGS     = 32,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] debug_reg_data,
    output logic [4:0]  debug_reg_addr,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    // state | meaning
    // IDLE  | waiting for start, line idle
    // HDR   | sending the sync header frame
    // FETCH | one cycle: address the core, capture its register value
    // BYTES | sending the 8 captured bytes back-to-back
    // FIN   | done pulse cycle, then back to IDLE
    typedef enum logic [2:0] {IDLE, HDR, FETCH, BYTES, FIN} state_t;

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      LAST_REG  = 5'(NUM_REGS - 1);

    state_t        state;
    logic [BW-1:0] baud;
    logic [3:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic [63:0]   shreg;
    logic [7:0]    cur_byte;
    logic          next_bit;
    logic          bit_end;

    // bit_cnt names the bit currently on the line; next_bit is what follows it
    always_comb begin
        cur_byte = (state == HDR) ? HEADER : shreg[63:56];
        next_bit = 1'b1;
        if (bit_cnt < 4'd8)
            next_bit = cur_byte[bit_cnt[2:0]];
        bit_end  = (baud == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            baud           <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            shreg          <= '0;
            debug_reg_addr <= '0;
            cpu_stall      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            uart_tx        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= HDR;
                        busy      <= 1'b1;
                        cpu_stall <= 1'b1;
                        uart_tx   <= 1'b0;
                        baud      <= '0;
                        bit_cnt   <= '0;
                    end
                end
                HDR, BYTES: begin
                    if (!bit_end) begin
                        baud <= baud + 1'b1;
                    end else begin
                        baud <= '0;
                        if (bit_cnt != 4'd9) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            uart_tx <= next_bit;
                        end else begin
                            bit_cnt <= '0;
                            if (state == HDR) begin
                                state          <= FETCH;
                                uart_tx        <= 1'b1;
                                debug_reg_addr <= '0;
                            end else if (byte_cnt != 3'd7) begin
                                byte_cnt <= byte_cnt + 3'd1;
                                shreg    <= shreg << 8;
                                uart_tx  <= 1'b0;
                            end else if (debug_reg_addr == LAST_REG) begin
                                state          <= FIN;
                                uart_tx        <= 1'b1;
                                byte_cnt       <= '0;
                                debug_reg_addr <= '0;
                                done           <= 1'b1;
                                busy           <= 1'b0;
                                cpu_stall      <= 1'b0;
                            end else begin
                                state          <= FETCH;
                                uart_tx        <= 1'b1;
                                byte_cnt       <= '0;
                                debug_reg_addr <= debug_reg_addr + 5'd1;
                            end
                        end
                    end
                end
                FETCH: begin
                    shreg    <= debug_reg_data;
                    uart_tx  <= 1'b0;
                    baud     <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    state    <= BYTES;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
